// File: rtl/program_sequencer.sv
// Program sequencer: loads a 256x8 program store, then feeds instructions to a
// datapath under run/step/halt control with a one-cycle datapath reset pulse.
module program_sequencer #(
  parameter logic [7:0] HALT_OPCODE = 8'hFF,
  parameter logic [7:0] NOP_OPCODE  = 8'h00
) (
  input  logic       _CLK,
  input  logic       RESET,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       run,
  input  logic       step,
  input  logic       halt,
  input  logic       clear,
  input  logic [7:0] PC,
  output logic [7:0] instruction,
  output logic       dp_reset,
  output logic       dp_enable,
  output logic [2:0] state,
  output logic [8:0] load_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_STEP   = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  logic [7:0] r_mem [0:255];
  logic [2:0] r_state;
  logic [8:0] r_wptr;
  logic [8:0] r_load_count;
  logic [7:0] r_instr;
  logic       r_dp_reset;
  logic       r_dp_enable;
  logic       r_load_ready;
  logic       r_step_req;
  // Set when the last fetch ended the program, so a later run restarts it.
  logic       r_restart;

  logic [2:0] w_next;
  logic       w_in_range;
  logic [7:0] w_fetch;
  logic       w_fetch_halt;
  logic       w_exec;
  logic       w_write;

  assign w_in_range   = ({1'b0, PC} < r_load_count);
  assign w_fetch      = w_in_range ? r_mem[PC] : NOP_OPCODE;
  assign w_fetch_halt = (w_fetch == HALT_OPCODE);
  assign w_exec       = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_write      = (r_state == S_LOAD) && load_valid && r_load_ready
                        && !clear && !load_start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (clear || halt)                              w_next = S_IDLE;
        else if (load_start)                            w_next = S_LOAD;
        else if ((run || step) && r_load_count != 9'd0) w_next = S_START;
      end
      S_LOAD: begin
        if (clear)           w_next = S_IDLE;
        else if (load_start) w_next = S_LOAD;
        else if (w_write && (load_last || r_wptr == 9'd255)) w_next = S_IDLE;
      end
      S_START: w_next = r_step_req ? S_STEP : S_RUN;
      S_RUN: begin
        if (clear)                           w_next = S_IDLE;
        else if (halt)                       w_next = S_HALTED;
        else if (load_start)                 w_next = S_LOAD;
        else if (!w_in_range || w_fetch_halt) w_next = S_HALTED;
      end
      S_STEP: begin
        if (clear)           w_next = S_IDLE;
        else if (load_start) w_next = S_LOAD;
        else                 w_next = S_HALTED;
      end
      S_HALTED: begin
        if (clear)           w_next = S_IDLE;
        else if (halt)       w_next = S_HALTED;
        else if (load_start) w_next = S_LOAD;
        else if (run)        w_next = r_restart ? S_START : S_RUN;
        else if (step)       w_next = S_STEP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge _CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_wptr       <= 9'd0;
      r_load_count <= 9'd0;
      r_instr      <= NOP_OPCODE;
      r_dp_reset   <= 1'b0;
      r_dp_enable  <= 1'b0;
      r_load_ready <= 1'b0;
      r_step_req   <= 1'b0;
      r_restart    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_dp_reset   <= (w_next == S_START);
      r_dp_enable  <= (w_next == S_RUN) || (w_next == S_STEP);
      r_load_ready <= (w_next == S_LOAD);
      if (w_next == S_START)
        r_step_req <= (r_state == S_IDLE) && !run;
      if (load_start && w_next == S_LOAD) begin
        r_wptr <= 9'd0;
      end else if (w_write) begin
        r_wptr       <= r_wptr + 9'd1;
        r_load_count <= r_wptr + 9'd1;
      end
      if (w_exec) begin
        r_instr   <= w_fetch;
        r_restart <= !w_in_range || w_fetch_halt;
      end
    end
  end

  always_ff @(posedge _CLK) begin
    if (w_write)
      r_mem[r_wptr[7:0]] <= load_data;
  end

  assign load_ready  = r_load_ready;
  assign instruction = r_instr;
  assign dp_reset    = r_dp_reset;
  assign dp_enable   = r_dp_enable;
  assign state       = r_state;
  assign load_count  = r_load_count;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer: load, run, halt opcode,
// step/resume, clear, load-while-running, full 256-word load and async reset.
module tb_program_sequencer;

  logic       clk;
  logic       rst;
  logic       load_start, load_valid, load_last;
  logic [7:0] load_data;
  logic       load_ready;
  logic       run, step, halt, clear;
  logic [7:0] PC;
  logic [7:0] instruction;
  logic       dp_reset, dp_enable;
  logic [2:0] state;
  logic [8:0] load_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tb_prog [0:255];
  logic [7:0] exp6 [0:5] = '{8'h73, 8'h4D, 8'h74, 8'hB7, 8'h06, 8'hC2};

  program_sequencer dut (
    ._CLK(clk), .RESET(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .run(run), .step(step), .halt(halt), .clear(clear), .PC(PC),
    .instruction(instruction), .dp_reset(dp_reset), .dp_enable(dp_enable),
    .state(state), .load_count(load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input bit with_last);
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1; load_data = tb_prog[i];
      load_last  = with_last && (i == n - 1);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic set_prog6();
    for (int i = 0; i < 6; i++) tb_prog[i] = exp6[i];
  endtask

  task automatic start_run();
    run = 1'b1; tick(); run = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; #1 rst = 1'b1; #2;
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_tests++; if (instruction !== 8'h00) begin n_fail++; $display("FAIL reset_instr got=%h exp=00", instruction); end
    n_tests++; if ({dp_reset, dp_enable, load_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=000", {dp_reset, dp_enable, load_ready}); end
    n_tests++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", load_count); end
    tick(); tick(); rst = 1'b0; tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_load();
    set_prog6();
    load_start = 1'b1; tick(); load_start = 1'b0;
    n_tests++; if (state !== 3'd1 || load_ready !== 1'b1) begin n_fail++; $display("FAIL load_enter got state=%0d ready=%b exp 1/1", state, load_ready); end
    load_valid = 1'b1; load_data = tb_prog[0]; tick();
    n_tests++; if (load_count !== 9'd1 || state !== 3'd1) begin n_fail++; $display("FAIL load_first got count=%0d state=%0d exp 1/1", load_count, state); end
    for (int i = 1; i < 6; i++) begin
      load_data = tb_prog[i]; load_last = (i == 5); tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    n_tests++; if (load_count !== 9'd6) begin n_fail++; $display("FAIL load_count got=%0d exp=6", load_count); end
    n_tests++; if (state !== 3'd0 || load_ready !== 1'b0) begin n_fail++; $display("FAIL load_exit got state=%0d ready=%b exp 0/0", state, load_ready); end
    $display("[TB] test_load done");
  endtask

  task automatic test_run();
    PC = 8'd0; run = 1'b1; tick(); run = 1'b0;
    n_tests++; if (state !== 3'd2 || dp_reset !== 1'b1 || dp_enable !== 1'b0) begin n_fail++; $display("FAIL run_start got state=%0d rst=%b en=%b exp 2/1/0", state, dp_reset, dp_enable); end
    tick();
    n_tests++; if (state !== 3'd3 || dp_reset !== 1'b0 || dp_enable !== 1'b1) begin n_fail++; $display("FAIL run_enter got state=%0d rst=%b en=%b exp 3/0/1", state, dp_reset, dp_enable); end
    for (int i = 0; i < 6; i++) begin
      PC = 8'(i); tick();
      n_tests++; if (instruction !== exp6[i] || state !== 3'd3) begin n_fail++; $display("FAIL run_fetch%0d got instr=%h state=%0d exp %h/3", i, instruction, state, exp6[i]); end
    end
    PC = 8'd6; tick();
    n_tests++; if (instruction !== 8'h00 || state !== 3'd5 || dp_enable !== 1'b0) begin n_fail++; $display("FAIL run_end got instr=%h state=%0d en=%b exp 00/5/0", instruction, state, dp_enable); end
    $display("[TB] test_run done");
  endtask

  task automatic test_halt_opcode();
    tb_prog[0] = 8'h01; tb_prog[1] = 8'hFF; tb_prog[2] = 8'h02;
    load_words(3, 1'b1);
    n_tests++; if (load_count !== 9'd3) begin n_fail++; $display("FAIL hop_count got=%0d exp=3", load_count); end
    PC = 8'd0; start_run();
    tick();
    n_tests++; if (instruction !== 8'h01 || state !== 3'd3) begin n_fail++; $display("FAIL hop_first got instr=%h state=%0d exp 01/3", instruction, state); end
    PC = 8'd1; tick();
    n_tests++; if (instruction !== 8'hFF || state !== 3'd5 || dp_enable !== 1'b0) begin n_fail++; $display("FAIL hop_halt got instr=%h state=%0d en=%b exp FF/5/0", instruction, state, dp_enable); end
    PC = 8'd0; run = 1'b1; tick(); run = 1'b0;
    n_tests++; if (state !== 3'd2 || dp_reset !== 1'b1) begin n_fail++; $display("FAIL hop_restart got state=%0d rst=%b exp 2/1", state, dp_reset); end
    tick();
    n_tests++; if (state !== 3'd3 || dp_reset !== 1'b0) begin n_fail++; $display("FAIL hop_rerun got state=%0d rst=%b exp 3/0", state, dp_reset); end
    tick();
    n_tests++; if (instruction !== 8'h01) begin n_fail++; $display("FAIL hop_refetch got=%h exp=01", instruction); end
    halt = 1'b1; tick(); halt = 1'b0;
    $display("[TB] test_halt_opcode done");
  endtask

  task automatic test_step_resume();
    set_prog6(); load_words(6, 1'b1);
    PC = 8'd0; start_run(); tick();
    PC = 8'd1; halt = 1'b1; tick(); halt = 1'b0;
    n_tests++; if (state !== 3'd5 || dp_enable !== 1'b0) begin n_fail++; $display("FAIL step_halted got state=%0d en=%b exp 5/0", state, dp_enable); end
    PC = 8'd3; step = 1'b1; tick(); step = 1'b0;
    n_tests++; if (state !== 3'd4 || dp_enable !== 1'b1) begin n_fail++; $display("FAIL step_enter got state=%0d en=%b exp 4/1", state, dp_enable); end
    tick();
    n_tests++; if (instruction !== 8'hB7 || state !== 3'd5 || dp_enable !== 1'b0) begin n_fail++; $display("FAIL step_exec got instr=%h state=%0d en=%b exp B7/5/0", instruction, state, dp_enable); end
    PC = 8'd4; tick();
    n_tests++; if (instruction !== 8'hB7 || dp_enable !== 1'b0) begin n_fail++; $display("FAIL step_hold got instr=%h en=%b exp B7/0", instruction, dp_enable); end
    run = 1'b1; tick(); run = 1'b0;
    n_tests++; if (state !== 3'd3 || dp_reset !== 1'b0 || dp_enable !== 1'b1) begin n_fail++; $display("FAIL resume got state=%0d rst=%b en=%b exp 3/0/1", state, dp_reset, dp_enable); end
    tick();
    n_tests++; if (instruction !== 8'h06) begin n_fail++; $display("FAIL resume_fetch got=%h exp=06", instruction); end
    $display("[TB] test_step_resume done");
  endtask

  task automatic test_halt_run_and_reset();
    PC = 8'd5; halt = 1'b1; run = 1'b1; tick(); halt = 1'b0; run = 1'b0;
    n_tests++; if (state !== 3'd5 || dp_enable !== 1'b0) begin n_fail++; $display("FAIL halt_vs_run got state=%0d en=%b exp 5/0", state, dp_enable); end
    run = 1'b1; tick(); run = 1'b0;
    PC = 8'd2; tick();
    n_tests++; if (state !== 3'd3 || instruction !== 8'h74) begin n_fail++; $display("FAIL pre_reset_run got state=%0d instr=%h exp 3/74", state, instruction); end
    #2 rst = 1'b1; #1;
    n_tests++; if (state !== 3'd0 || instruction !== 8'h00 || {dp_reset, dp_enable, load_ready} !== 3'b000 || load_count !== 9'd0) begin n_fail++; $display("FAIL async_reset got state=%0d instr=%h ctrl=%b count=%0d", state, instruction, {dp_reset, dp_enable, load_ready}, load_count); end
    #1 rst = 1'b0;
    run = 1'b1; tick(); tick(); run = 1'b0;
    n_tests++; if (state !== 3'd0 || dp_reset !== 1'b0) begin n_fail++; $display("FAIL run_after_reset got state=%0d rst=%b exp 0/0", state, dp_reset); end
    $display("[TB] test_halt_run_and_reset done");
  endtask

  task automatic test_clear();
    set_prog6(); load_words(6, 1'b1);
    PC = 8'd0; start_run(); PC = 8'd2;
    clear = 1'b1; tick(); clear = 1'b0;
    n_tests++; if (state !== 3'd0 || dp_enable !== 1'b0 || load_count !== 9'd6) begin n_fail++; $display("FAIL clear got state=%0d en=%b count=%0d exp 0/0/6", state, dp_enable, load_count); end
    run = 1'b1; tick(); run = 1'b0;
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL clear_rerun got state=%0d exp=2", state); end
    tick();
    $display("[TB] test_clear done");
  endtask

  task automatic test_load_during_run();
    PC = 8'd1; load_start = 1'b1; tick(); load_start = 1'b0;
    n_tests++; if (state !== 3'd1 || dp_enable !== 1'b0 || load_ready !== 1'b1) begin n_fail++; $display("FAIL run_to_load got state=%0d en=%b ready=%b exp 1/0/1", state, dp_enable, load_ready); end
    load_valid = 1'b1; load_data = 8'hAA; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    n_tests++; if (load_count !== 9'd1 || state !== 3'd0) begin n_fail++; $display("FAIL reload_one got count=%0d state=%0d exp 1/0", load_count, state); end
    $display("[TB] test_load_during_run done");
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 256; i++) tb_prog[i] = 8'(i) ^ 8'h5A;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1; load_data = tb_prog[i]; tick();
      if (i == 254) begin
        n_tests++; if (state !== 3'd1 || load_ready !== 1'b1 || load_count !== 9'd255) begin n_fail++; $display("FAIL full_255 got state=%0d ready=%b count=%0d exp 1/1/255", state, load_ready, load_count); end
      end
    end
    load_valid = 1'b0;
    n_tests++; if (load_count !== 9'd256 || state !== 3'd0 || load_ready !== 1'b0) begin n_fail++; $display("FAIL full_256 got count=%0d state=%0d ready=%b exp 256/0/0", load_count, state, load_ready); end
    load_valid = 1'b1; load_data = 8'h11; tick(); load_valid = 1'b0;
    n_tests++; if (load_count !== 9'd256 || state !== 3'd0) begin n_fail++; $display("FAIL full_257 got count=%0d state=%0d exp 256/0", load_count, state); end
    PC = 8'd0; start_run(); tick();
    n_tests++; if (instruction !== 8'h5A) begin n_fail++; $display("FAIL full_pc0 got=%h exp=5A", instruction); end
    PC = 8'd255; tick();
    n_tests++; if (instruction !== 8'hA5 || state !== 3'd3) begin n_fail++; $display("FAIL full_pc255 got instr=%h state=%0d exp A5/3", instruction, state); end
    halt = 1'b1; tick(); halt = 1'b0;
    $display("[TB] test_full_load done");
  endtask

  initial begin
    rst = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 8'h00;
    run = 1'b0; step = 1'b0; halt = 1'b0; clear = 1'b0; PC = 8'h00;
    test_reset();
    test_load();
    test_run();
    test_halt_opcode();
    test_step_resume();
    test_halt_run_and_reset();
    test_clear();
    test_load_during_run();
    test_full_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter HALT_OPCODE, default 8'hFF, instruction value that stops execution when fetched.
REQ-002 Parameter NOP_OPCODE, default 8'h00, instruction driven whenever no valid program word is presented.
REQ-003 _CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RESET  input  1  reset, asynchronous and active-high.
REQ-005 load_start  input  1  begin program load; write pointer cleared to 0.
REQ-006 load_valid  input  1  load_data valid this cycle.
REQ-007 load_data  input  8  program word to store.
REQ-008 load_last  input  1  qualifies the final word of a load (with load_valid).
REQ-009 load_ready  output  1  sequencer accepts a word this cycle.
REQ-010 run / step / halt / clear  input  1 each  run control requests, level-sampled.
REQ-011 PC  input  8  program counter from the datapath.
REQ-012 instruction  output  8  registered instruction to the datapath.
REQ-013 dp_reset  output  1  reset pulse to the datapath.
REQ-014 dp_enable  output  1  datapath advance enable.
REQ-015 state  output  3  FSM encoding: IDLE=0, LOAD=1, START=2, RUN=3, STEP=4, HALTED=5.
REQ-016 load_count  output  9  number of stored program words, 0..256.

Function
REQ-017 Storage SHALL be 256x8, written only in LOAD, read at address PC.
REQ-018 IDLE: load_start -> LOAD; else run or step with load_count!=0 -> START (step recorded); run/step with load_count==0 ignored.
REQ-019 LOAD: load_ready=1 while write pointer <256; load_valid&&load_ready writes mem[ptr], ptr+1, load_count=ptr+1 on the same edge.
REQ-020 LOAD exits to IDLE after a write with load_last=1, or after the 256th write; load_ready=0 from that edge.
REQ-021 load_valid with load_ready=0 SHALL be ignored, no write, no pointer wrap.
REQ-022 START lasts exactly 1 cycle with dp_reset=1, dp_enable=0; next state RUN, or STEP if step recorded.
REQ-023 RUN: dp_enable=1; each edge instruction <= mem[PC] if PC<load_count, else NOP_OPCODE (1-cycle latency).
REQ-024 RUN -> HALTED on halt=1, on PC>=load_count, or on the edge that registers HALT_OPCODE; dp_enable=0 from that edge.
REQ-025 STEP: dp_enable=1 for exactly one cycle, instruction updated once per REQ-023, then HALTED.
REQ-026 HALTED: dp_enable=0, instruction held; run -> RUN (resume, no dp_reset) unless last instruction was HALT_OPCODE or PC>=load_count, in which case run -> START; step -> STEP; load_start -> LOAD.
REQ-027 clear in any state except START SHALL go to IDLE next edge; load_count preserved.
REQ-028 Priority when simultaneous: clear > halt > load_start > run > step.
REQ-029 load_start in RUN or STEP SHALL first halt (dp_enable=0 same edge) and enter LOAD, never writing memory while dp_enable=1.
REQ-030 dp_reset SHALL be asserted only in START; outputs glitch-free (registered).

Reset
REQ-031 RESET=1 SHALL immediately force state=IDLE, instruction=NOP_OPCODE, dp_reset=0, dp_enable=0, load_ready=0, load_count=0, write pointer=0; memory contents undefined.
REQ-032 RESET asserted mid-LOAD or mid-RUN SHALL abort without further writes; after release, run SHALL be ignored until a new load.

Verification
REQ-033 Load 6 words 73,4D,74,B7,06,C2 (last with load_last) -> load_count=6, state=IDLE, load_ready=0.
REQ-034 run after load -> one cycle dp_reset=1, then RUN; PC=0..5 yields instruction 73,4D,74,B7,06,C2 one cycle later; PC=6 -> instruction=00, HALTED.
REQ-035 Program 01,FF,02; run -> HALTED on edge instruction=FF; run again -> START pulse then RUN from reset.
REQ-036 In HALTED, step pulse -> dp_enable high exactly 1 cycle, instruction=mem[PC], back to HALTED.
REQ-037 Load 256 words without load_last -> load_count=256, 257th load_valid ignored, state=IDLE.
REQ-038 halt and run asserted same cycle in RUN -> HALTED; RESET pulse during RUN -> all outputs at reset values asynchronously, run ignored until reload.
